// File: rtl/quadrature_gen.sv
// quadrature_gen: quadrature encoder emulator; emits Gray-coded A/B steps per move command.
// Latency: first transition Pe cycles after command accept, then one every Pe cycles.
// Backpressure: cmd_ready = !busy; commands offered while a move runs are not latched.
//
// Ports:
//   clk, rst_n         clock, asynchronous active-low reset
//   cmd_steps/period   move length (transitions) and clock cycles per transition (0 acts as 1)
//   cmd_dir            1 = forward (11->10->00->01), 0 = reverse
//   cmd_valid/ready    command handshake; ready whenever no move is in progress
//   abort              ends the running move at the next edge (a coincident step still happens)
//   pos_clear          zeroes position before that cycle's step is counted
//   out_a, out_b       registered quadrature outputs
//   position           net step count, two's complement, wraps
//   busy, done, aborted  move status; done pulses for one cycle, aborted qualifies it
module quadrature_gen #(
  parameter int COUNTER_WIDTH = 32
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [COUNTER_WIDTH-1:0] cmd_steps,
  input  logic [COUNTER_WIDTH-1:0] cmd_period,
  input  logic                     cmd_dir,
  input  logic                     cmd_valid,
  output logic                     cmd_ready,
  input  logic                     abort,
  input  logic                     pos_clear,
  output logic                     out_a,
  output logic                     out_b,
  output logic [COUNTER_WIDTH-1:0] position,
  output logic                     busy,
  output logic                     done,
  output logic                     aborted
);

  localparam logic ST_IDLE = 1'b0;
  localparam logic ST_RUN  = 1'b1;

  localparam logic [COUNTER_WIDTH-1:0] ZERO = '0;
  localparam logic [COUNTER_WIDTH-1:0] ONE  = COUNTER_WIDTH'(1);

  logic                     state;
  logic                     dir_q;
  logic [1:0]               phase;
  logic [1:0]               phase_next;
  logic [COUNTER_WIDTH-1:0] period_m1;
  logic [COUNTER_WIDTH-1:0] cmd_period_m1;
  logic [COUNTER_WIDTH-1:0] timer;
  logic [COUNTER_WIDTH-1:0] remaining;
  logic [COUNTER_WIDTH-1:0] pos_base;
  logic                     step;

  assign busy      = (state == ST_RUN);
  assign cmd_ready = ~busy;

  // A step fires when the per-transition timer has run down.
  assign step = busy && (timer == ZERO);

  // Period 0 behaves like period 1, so the reload value saturates at zero.
  assign cmd_period_m1 = (cmd_period == ZERO) ? ZERO : (cmd_period - ONE);

  // Phase index 0..3 maps to (A,B) = 11,10,00,01; forward increments, reverse decrements.
  always_comb begin
    phase_next = phase;
    if (step) begin
      phase_next = dir_q ? (phase + 2'd1) : (phase - 2'd1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      dir_q     <= 1'b0;
      period_m1 <= '0;
      timer     <= '0;
      remaining <= '0;
      phase     <= 2'd1;
      out_a     <= 1'b1;
      out_b     <= 1'b0;
      done      <= 1'b0;
      aborted   <= 1'b0;
    end else begin
      done  <= 1'b0;
      phase <= phase_next;
      // Outputs are decoded from the next phase so they stay in step with it as flops.
      out_a <= ~phase_next[1];
      out_b <= ~(phase_next[1] ^ phase_next[0]);
      case (state)
        ST_IDLE: begin
          if (cmd_valid) begin
            dir_q     <= cmd_dir;
            period_m1 <= cmd_period_m1;
            aborted   <= 1'b0;
            if (cmd_steps == ZERO) begin
              done <= 1'b1;
            end else begin
              state     <= ST_RUN;
              timer     <= cmd_period_m1;
              remaining <= cmd_steps;
            end
          end
        end
        ST_RUN: begin
          if (step) begin
            remaining <= remaining - ONE;
            timer     <= period_m1;
          end else begin
            timer <= timer - ONE;
          end
          if (abort) begin
            state   <= ST_IDLE;
            done    <= 1'b1;
            aborted <= 1'b1;
          end else if (step && (remaining == ONE)) begin
            state <= ST_IDLE;
            done  <= 1'b1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Clear takes effect before the step of the same cycle is added.
  assign pos_base = pos_clear ? ZERO : position;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      position <= '0;
    end else if (step) begin
      position <= dir_q ? (pos_base + ONE) : (pos_base - ONE);
    end else begin
      position <= pos_base;
    end
  end

endmodule
